// File: rtl/qei_encoder_emulator.sv
// qei_encoder_emulator
//   Transmit side of a quadrature encoder interface. Steps the emitted
//   position toward a commanded target, one quadrature edge per count, with a
//   programmable number of clocks between edges. The index output is high
//   while the position within the revolution is zero.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   cmd_valid  move command present
//   cmd_ready  high while idle; command accepted on cmd_valid & cmd_ready
//   cmd_pos    signed target position (counts)
//   cmd_div    clocks between edges (0 behaves as 1)
//   halt       abort the move in progress
//   enc_a      quadrature phase A
//   enc_b      quadrature phase B
//   enc_z      index
//   position   current emitted count (signed)
//   busy       move in progress
//   done       one-cycle pulse on move completion
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a command; outputs hold
// RUN   | emitting edges toward target, one every div clocks

module qei_encoder_emulator #(
  parameter int POS_W = 32,
  parameter int CPR   = 4000,
  parameter int DIV_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [POS_W-1:0] cmd_pos,
  input  logic        [DIV_W-1:0] cmd_div,
  input  logic                    halt,
  output logic                    enc_a,
  output logic                    enc_b,
  output logic                    enc_z,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = (CPR > 1) ? $clog2(CPR) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CPR - 1);
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                    state;
  logic signed [POS_W-1:0]   target;
  logic        [DIV_W-1:0]   div_q;
  logic        [DIV_W-1:0]   timer;
  logic        [IDX_W-1:0]   idx;

  logic                      fwd;
  logic        [DIV_W-1:0]   div_eff;
  logic signed [POS_W-1:0]   pos_step;
  logic        [IDX_W-1:0]   idx_step;
  logic                      a_step;
  logic                      b_step;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN);
  assign div_eff   = (cmd_div == '0) ? DIV_ONE : cmd_div;

  // Sign of the modular difference picks the shorter way round, so a move
  // across the two's complement wrap goes through it rather than the long way.
  assign fwd = ($signed(target - position) >= 0);

  always_comb begin
    pos_step = position;
    idx_step = idx;
    a_step   = enc_a;
    b_step   = enc_b;
    if (fwd) begin
      pos_step = position + POS_ONE;
      idx_step = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      // forward gray walk 00 -> 10 -> 11 -> 01 -> 00
      if (enc_a == enc_b) a_step = ~enc_a;
      else                b_step = ~enc_b;
    end else begin
      pos_step = position - POS_ONE;
      idx_step = (idx == '0) ? IDX_LAST : idx - 1'b1;
      // reverse walk 00 -> 01 -> 11 -> 10 -> 00
      if (enc_a == enc_b) b_step = ~enc_b;
      else                a_step = ~enc_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      target   <= '0;
      div_q    <= DIV_ONE;
      timer    <= '0;
      idx      <= '0;
      position <= '0;
      enc_a    <= 1'b0;
      enc_b    <= 1'b0;
      enc_z    <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // halt is ignored here, even alongside cmd_valid
          if (cmd_valid) begin
            target <= cmd_pos;
            div_q  <= div_eff;
            timer  <= div_eff - DIV_ONE;
            if (cmd_pos == position) done  <= 1'b1;
            else                     state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // The final edge wins over a coincident halt; any other halt aborts
          // before the edge so the outputs freeze where they are.
          if (timer == '0 && (pos_step == target || !halt)) begin
            position <= pos_step;
            idx      <= idx_step;
            enc_a    <= a_step;
            enc_b    <= b_step;
            enc_z    <= (idx_step == '0);
            timer    <= div_q - DIV_ONE;
            if (pos_step == target) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end else if (halt) begin
            state <= ST_IDLE;
          end else begin
            timer <= timer - DIV_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qei_encoder_emulator.sv
module tb_qei_encoder_emulator;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // default-parameter instance
  logic        reset, cmd_valid, cmd_ready, halt;
  logic [31:0] cmd_pos, position;
  logic [15:0] cmd_div;
  logic        enc_a, enc_b, enc_z, busy, done;

  // small instance: 8-bit position, CPR = 8
  logic        reset8, cmd_valid8, cmd_ready8, halt8;
  logic [7:0]  cmd_pos8, position8;
  logic [3:0]  cmd_div8;
  logic        enc_a8, enc_b8, enc_z8, busy8, done8;

  // A/B as a function of position mod 4 (position 0 after reset is 00)
  logic [1:0] ab_tab [4];
  initial begin
    ab_tab[0] = 2'b00; ab_tab[1] = 2'b10; ab_tab[2] = 2'b11; ab_tab[3] = 2'b01;
  end

  qei_encoder_emulator dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pos(cmd_pos), .cmd_div(cmd_div), .halt(halt),
    .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z), .position(position),
    .busy(busy), .done(done)
  );

  qei_encoder_emulator #(.POS_W(8), .CPR(8), .DIV_W(4)) dut8 (
    .clk(clk), .reset(reset8), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
    .cmd_pos(cmd_pos8), .cmd_div(cmd_div8), .halt(halt8),
    .enc_a(enc_a8), .enc_b(enc_b8), .enc_z(enc_z8), .position(position8),
    .busy(busy8), .done(done8)
  );

  // Drive a command for exactly one rising edge; returns just after the
  // accepting edge (at the following falling edge).
  task automatic send(input logic [31:0] p, input logic [15:0] d);
    @(negedge clk);
    cmd_pos = p; cmd_div = d; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send8(input logic [7:0] p, input logic [3:0] d);
    @(negedge clk);
    cmd_pos8 = p; cmd_div8 = d; cmd_valid8 = 1'b1;
    @(negedge clk);
    cmd_valid8 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; reset8 = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({enc_a, enc_b, enc_z, busy, cmd_ready, done} !== 6'b001010) begin
      bad++;
      $display("FAIL reset_outputs got abz_busy_rdy_done=%b want 001010",
               {enc_a, enc_b, enc_z, busy, cmd_ready, done});
    end
    total++;
    if (position !== 32'd0) begin
      bad++; $display("FAIL reset_position got %0d want 0", position);
    end
    total++;
    if ({enc_a8, enc_b8, enc_z8, busy8, cmd_ready8, done8, position8} !== {6'b001010, 8'd0}) begin
      bad++; $display("FAIL reset_small got %b want 001010_00000000",
                      {enc_a8, enc_b8, enc_z8, busy8, cmd_ready8, done8, position8});
    end
    reset = 1'b0; reset8 = 1'b0;
  endtask

  // 0 -> 5, div 4: edges 4, 8, ... 20 clocks after the accepting edge
  task automatic test_forward;
    logic [31:0] exp_pos;
    exp_pos = 32'd0;
    send(32'd5, 16'd4);
    total++;
    if ({busy, cmd_ready, done} !== 3'b100) begin
      bad++; $display("FAIL fwd_start busy_rdy_done got %b want 100", {busy, cmd_ready, done});
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c % 4 == 0) exp_pos = exp_pos + 32'd1;
      total++;
      if (position !== exp_pos || {enc_a, enc_b} !== ab_tab[exp_pos[1:0]] ||
          enc_z !== (exp_pos == 32'd0)) begin
        bad++;
        $display("FAIL fwd_edge c=%0d got pos=%0d ab=%b z=%b want pos=%0d ab=%b z=%b",
                 c, position, {enc_a, enc_b}, enc_z, exp_pos, ab_tab[exp_pos[1:0]],
                 exp_pos == 32'd0);
      end
      total++;
      if (done !== (c == 20) || busy !== (c != 20)) begin
        bad++; $display("FAIL fwd_flags c=%0d got done=%b busy=%b", c, done, busy);
      end
    end
  endtask

  // 5 -> 2 with div 0: one edge per clock, A/B 00, 01, 11
  task automatic test_reverse_fast;
    logic [31:0] exp_pos;
    exp_pos = 32'd5;
    send(32'd2, 16'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      exp_pos = exp_pos - 32'd1;
      total++;
      if (position !== exp_pos || {enc_a, enc_b} !== ab_tab[exp_pos[1:0]] ||
          done !== (c == 3)) begin
        bad++;
        $display("FAIL rev_edge c=%0d got pos=%0d ab=%b done=%b want pos=%0d ab=%b done=%b",
                 c, position, {enc_a, enc_b}, done, exp_pos, ab_tab[exp_pos[1:0]], c == 3);
      end
    end
    @(negedge clk);
    total++;
    if (position !== 32'd2 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rev_after got pos=%0d done=%b rdy=%b want 2 0 1",
                      position, done, cmd_ready);
    end
  endtask

  task automatic test_halt;
    // 2 -> 102 div 2; command while busy ignored; halt after 10th edge
    send(32'd102, 16'd2);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 5) begin
        total++;
        if (cmd_ready !== 1'b0) begin
          bad++; $display("FAIL busy_ready got %b want 0", cmd_ready);
        end
        cmd_pos = 32'd50; cmd_div = 16'd1; cmd_valid = 1'b1;
      end
      if (c == 6) cmd_valid = 1'b0;
    end
    total++;
    if (position !== 32'd12) begin
      bad++; $display("FAIL halt_pre got pos=%0d want 12", position);
    end
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    total++;
    if (position !== 32'd12 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL halt_stop got pos=%0d busy=%b rdy=%b done=%b want 12 0 1 0",
                      position, busy, cmd_ready, done);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (position !== 32'd12 || done !== 1'b0 || {enc_a, enc_b} !== ab_tab[0]) begin
        bad++; $display("FAIL halt_hold got pos=%0d done=%b ab=%b want 12 0 00",
                        position, done, {enc_a, enc_b});
      end
    end
    // halt coinciding with the final edge: edge happens and done pulses
    send(32'd13, 16'd3);
    @(negedge clk);
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    total++;
    if (position !== 32'd13 || done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL halt_final got pos=%0d done=%b busy=%b want 13 1 0",
                      position, done, busy);
    end
    // halt with cmd_valid in IDLE: command still accepted
    @(negedge clk);
    cmd_pos = 32'd15; cmd_div = 16'd1; cmd_valid = 1'b1; halt = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; halt = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL halt_idle_accept got busy=%b want 1", busy);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (position !== 32'd15 || done !== 1'b1) begin
      bad++; $display("FAIL halt_idle_move got pos=%0d done=%b want 15 1", position, done);
    end
  endtask

  task automatic test_reset_mid_move;
    send(32'd1000, 16'd1);
    repeat (5) @(negedge clk);
    total++;
    if (position !== 32'd20 || busy !== 1'b1) begin
      bad++; $display("FAIL mid_pre got pos=%0d busy=%b want 20 1", position, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({enc_a, enc_b, enc_z, busy, cmd_ready, done} !== 6'b001010 || position !== 32'd0) begin
      bad++; $display("FAIL mid_reset got abz_busy_rdy_done=%b pos=%0d want 001010 0",
                      {enc_a, enc_b, enc_z, busy, cmd_ready, done}, position);
    end
    @(negedge clk);
    total++;
    if (position !== 32'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_after got pos=%0d busy=%b want 0 0", position, busy);
    end
  endtask

  // CPR = 8 index behaviour
  task automatic test_index;
    logic [7:0] exp_pos;
    send8(8'hFF, 4'd1);
    @(negedge clk);
    total++;
    if (position8 !== 8'hFF || enc_z8 !== 1'b0 || {enc_a8, enc_b8} !== 2'b01 || done8 !== 1'b1) begin
      bad++; $display("FAIL idx_rev got pos=%0d z=%b ab=%b done=%b want -1 0 01 1",
                      $signed(position8), enc_z8, {enc_a8, enc_b8}, done8);
    end
    exp_pos = 8'hFF;
    send8(8'd8, 4'd2);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c % 2 == 0) exp_pos = exp_pos + 8'd1;
      total++;
      if (position8 !== exp_pos || {enc_a8, enc_b8} !== ab_tab[exp_pos[1:0]] ||
          enc_z8 !== (exp_pos == 8'd0 || exp_pos == 8'd8)) begin
        bad++;
        $display("FAIL idx_fwd c=%0d got pos=%0d z=%b ab=%b want pos=%0d z=%b ab=%b",
                 c, $signed(position8), enc_z8, {enc_a8, enc_b8}, $signed(exp_pos),
                 exp_pos == 8'd0 || exp_pos == 8'd8, ab_tab[exp_pos[1:0]]);
      end
    end
    total++;
    if (done8 !== 1'b1) begin
      bad++; $display("FAIL idx_done got %b want 1", done8);
    end
  endtask

  // 8-bit wrap: 126 -> -127 takes three forward edges through 127, -128
  task automatic test_wrap;
    logic [7:0] exp_pos;
    int cnt;
    send8(8'd126, 4'd1);
    cnt = 0;
    while (done8 !== 1'b1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    total++;
    if (done8 !== 1'b1 || position8 !== 8'd126 || {enc_a8, enc_b8} !== 2'b11) begin
      bad++; $display("FAIL wrap_setup got done=%b pos=%0d ab=%b want 1 126 11",
                      done8, position8, {enc_a8, enc_b8});
    end
    exp_pos = 8'd126;
    send8(8'h81, 4'd3);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c % 3 == 0) exp_pos = exp_pos + 8'd1;
      total++;
      if (position8 !== exp_pos || {enc_a8, enc_b8} !== ab_tab[exp_pos[1:0]] ||
          done8 !== (c == 9)) begin
        bad++;
        $display("FAIL wrap_edge c=%0d got pos=%0d ab=%b done=%b want pos=%0d ab=%b done=%b",
                 c, $signed(position8), {enc_a8, enc_b8}, done8, $signed(exp_pos),
                 ab_tab[exp_pos[1:0]], c == 9);
      end
    end
    send8(8'h81, 4'd1);
    total++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || position8 !== 8'h81 || cmd_ready8 !== 1'b1) begin
      bad++; $display("FAIL same_target got done=%b busy=%b pos=%0d rdy=%b want 1 0 -127 1",
                      done8, busy8, $signed(position8), cmd_ready8);
    end
    @(negedge clk);
    total++;
    if (done8 !== 1'b0 || position8 !== 8'h81 || {enc_a8, enc_b8} !== ab_tab[1]) begin
      bad++; $display("FAIL same_after got done=%b pos=%0d ab=%b want 0 -127 10",
                      done8, $signed(position8), {enc_a8, enc_b8});
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_pos = '0; cmd_div = '0; halt = 1'b0;
    cmd_valid8 = 1'b0; cmd_pos8 = '0; cmd_div8 = '0; halt8 = 1'b0;
    test_reset;
    test_forward;
    test_reverse_fast;
    test_halt;
    test_reset_mid_move;
    test_index;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
